ram8x4_loader: RTL and testbench

- 8-word x 4-bit writable memory with a burst-load engine. It is the write-side counterpart of the 8x4 lookup ROM.
- Contents are filled either by single direct writes or by a valid/ready stream burst starting at a base address.
- Read-out uses the same combinational addr -> data port shape as the ROM, so downstream logic can swap the ROM for this block without change.

---
 rtl/ram8x4_pkg.sv | 19 +
 rtl/ram8x4_loader_if.sv | 32 +++
 rtl/ram8x4_core.sv | 33 +++
 rtl/ram8x4_loader.sv | 101 ++++++++++
 tb/tb_ram8x4_loader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ram8x4_pkg.sv
// Shared constants, FSM encoding and init pattern for the 8x4 loader RAM.
// Optional RAM8X4_INIT_EN selects the ROM-matching reset contents.
package ram8x4_pkg;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] i);
        return {i, 1'b0};
    endfunction

endpackage

// File: rtl/ram8x4_loader_if.sv
// Bus bundle for ram8x4_loader: read port, direct write, burst stream.
// The master side drives requests; the slave side is the memory block.
interface ram8x4_loader_if;
    import ram8x4_pkg::*;

    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len_m1;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          busy;
    logic          done;

    modport master (
        output addr, wr_en, wr_addr, wr_data,
        output start, base_addr, len_m1, in_valid, in_data,
        input  data, in_ready, busy, done
    );

    modport slave (
        input  addr, wr_en, wr_addr, wr_data,
        input  start, base_addr, len_m1, in_valid, in_data,
        output data, in_ready, busy, done
    );

endinterface

// File: rtl/ram8x4_core.sv
// 8x4 storage: one synchronous write port, async read, reset/init.
// RAM8X4_INIT_EN loads mem[i]=2*i on reset instead of clearing.
module ram8x4_core
    import ram8x4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef RAM8X4_INIT_EN
                mem_q[i] <= init_word(AW'(i));
`else
                mem_q[i] <= '0;
`endif
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram8x4_loader.sv
// Writable 8x4 RAM with direct writes and a valid/ready burst loader.
// Build option RAM8X4_INIT_EN: reset contents mirror the 8x4 ROM.
module ram8x4_loader
    import ram8x4_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ram8x4_loader_if.slave bus
);

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] cnt_q;
    logic          in_ready_q;
    logic          busy_q;
    logic          done_q;

    logic          beat;
    logic          dir_wr;
    logic          we_d;
    logic [AW-1:0] waddr_d;
    logic [DW-1:0] wdata_d;

    assign beat   = (state_q == LOAD) && bus.in_valid && in_ready_q;
    assign dir_wr = (state_q == IDLE) && bus.wr_en;

    // Burst beats and direct writes are mutually exclusive by state.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = bus.wr_addr;
        wdata_d = bus.wr_data;
        if (beat) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = bus.in_data;
        end else if (dir_wr) begin
            we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= LOAD;
                        ptr_q      <= bus.base_addr;
                        cnt_q      <= bus.len_m1;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        ptr_q <= ptr_q + AW'(1);
                        if (cnt_q == '0) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - AW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    ram8x4_core u_core (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_d),
        .waddr_i (waddr_d),
        .wdata_i (wdata_d),
        .raddr_i (bus.addr),
        .rdata_o (bus.data)
    );

endmodule

// File: tb/tb_ram8x4_loader.sv
// Directed bench for ram8x4_loader: reset image, direct write, bursts.
// Define RAM8X4_INIT_EN to check the ROM-matching reset contents.
module tb_ram8x4_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    ram8x4_loader_if bus ();

    ram8x4_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rst_word(input int i);
`ifdef RAM8X4_INIT_EN
        return 4'(2 * i);
`else
        return 4'h0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input int a, input logic [3:0] exp);
        bus.addr = 3'(a);
        #1;
        chk(tag, 8'(bus.data), 8'(exp));
    endtask

    initial begin
        bus.addr      = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len_m1    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        // reset image
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 8'(bus.in_ready), 8'h0);
        chk("rst_busy", 8'(bus.busy), 8'h0);
        chk("rst_done", 8'(bus.done), 8'h0);
        for (int i = 0; i < 8; i++) rd($sformatf("rst_mem%0d", i), i, rst_word(i));

        // direct write, old value visible during write cycle
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 4'hA;
        rd("dw_old", 5, rst_word(5));
        tick();
        bus.wr_en = 1'b0;
        rd("dw_new", 5, 4'hA);

        // burst base 6, 4 beats with a gap, wraps to 0/1
        bus.start     = 1'b1;
        bus.base_addr = 3'd6;
        bus.len_m1    = 3'd3;
        chk("pre_start_ready", 8'(bus.in_ready), 8'h0);
        tick();
        bus.start = 1'b0;
        chk("b_ready", 8'(bus.in_ready), 8'h1);
        chk("b_busy", 8'(bus.busy), 8'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        tick();
        bus.in_data = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("b_gap_ready", 8'(bus.in_ready), 8'h1);
        chk("b_gap_done", 8'(bus.done), 8'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd3;
        tick();
        chk("b_pre_done", 8'(bus.done), 8'h0);
        bus.in_data = 4'd4;
        tick();
        bus.in_valid = 1'b0;
        chk("b_done", 8'(bus.done), 8'h1);
        chk("b_done_busy", 8'(bus.busy), 8'h1);
        chk("b_done_ready", 8'(bus.in_ready), 8'h0);
        tick();
        chk("b_done_clr", 8'(bus.done), 8'h0);
        chk("b_busy_clr", 8'(bus.busy), 8'h0);
        rd("b_mem6", 6, 4'd1);
        rd("b_mem7", 7, 4'd2);
        rd("b_mem0", 0, 4'd3);
        rd("b_mem1", 1, 4'd4);
        rd("b_mem5", 5, 4'hA);

        // wr_en and start ignored while loading
        bus.start     = 1'b1;
        bus.base_addr = 3'd4;
        bus.len_m1    = 3'd1;
        tick();
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 3'd3;
        bus.wr_data   = 4'hF;
        bus.base_addr = 3'd0;
        bus.len_m1    = 3'd7;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'd5;
        tick();
        bus.wr_en   = 1'b0;
        bus.start   = 1'b0;
        bus.in_data = 4'd6;
        tick();
        bus.in_valid = 1'b0;
        chk("ign_done", 8'(bus.done), 8'h1);
        tick();
        chk("ign_busy", 8'(bus.busy), 8'h0);
        rd("ign_mem3", 3, rst_word(3));
        rd("ign_mem4", 4, 4'd5);
        rd("ign_mem5", 5, 4'd6);
        rd("ign_mem0", 0, 4'd3);

        // reset aborts an 8-beat burst after 2 beats
        bus.start     = 1'b1;
        bus.base_addr = 3'd0;
        bus.len_m1    = 3'd7;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd8;
        tick();
        bus.in_data = 4'd9;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_ready", 8'(bus.in_ready), 8'h0);
        chk("ab_busy", 8'(bus.busy), 8'h0);
        chk("ab_done", 8'(bus.done), 8'h0);
        tick();
        chk("ab_done2", 8'(bus.done), 8'h0);
        rd("ab_mem0", 0, rst_word(0));
        rd("ab_mem1", 1, rst_word(1));
        rd("ab_mem5", 5, rst_word(5));
        rd("ab_mem6", 6, rst_word(6));

        // direct write and 1-beat burst on the same word
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 3'd2;
        bus.wr_data   = 4'd7;
        bus.start     = 1'b1;
        bus.base_addr = 3'd2;
        bus.len_m1    = 3'd0;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        rd("co_mem2_dw", 2, 4'd7);
        chk("co_ready", 8'(bus.in_ready), 8'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd9;
        tick();
        bus.in_valid = 1'b0;
        rd("co_mem2_beat", 2, 4'd9);
        rd("co_mem3", 3, rst_word(3));
        chk("co_done", 8'(bus.done), 8'h1);
        tick();
        chk("co_done_clr", 8'(bus.done), 8'h0);
        chk("co_busy_clr", 8'(bus.busy), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
